// File: rtl/prefetch.sv
// Instruction prefetch stage: fetches 16-bit code words over the memory bus,
// splits them into bytes and queues them in a show-ahead byte FIFO for the decoder.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   load_new_ip, new_cs, new_ip   redirect pulse and target segment:offset
//   fifo_rd_en                    pop head byte (ignored while empty)
//   fifo_rd_data, fifo_empty      head byte (combinational) and empty flag
//   mem_access, mem_address       registered bus request and word address
//   mem_ack, mem_data             single-cycle completion and fetched word
module prefetch #(
  parameter int unsigned FIFO_DEPTH = 6,
  parameter logic [15:0] RESET_CS   = 16'hFFFF,
  parameter logic [15:0] RESET_IP   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_new_ip,
  input  logic [15:0] new_cs,
  input  logic [15:0] new_ip,
  input  logic        fifo_rd_en,
  output logic [7:0]  fifo_rd_data,
  output logic        fifo_empty,
  output logic        mem_access,
  input  logic        mem_ack,
  output logic [18:0] mem_address,
  input  logic [15:0] mem_data
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t           state;
  logic [15:0]      cs;
  logic [15:0]      fetch_ip;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       ring [FIFO_DEPTH];

  logic [18:0]      word_addr_c;
  logic             pop_c;
  logic             ack_push_c;
  logic             space_ok_c;
  logic [CNT_W-1:0] push_cnt_c;
  logic [PTR_W-1:0] wr_ptr_1_c;
  logic [PTR_W-1:0] wr_ptr_2_c;

  // Ring pointer advance with wrap at a non-power-of-two depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Datapath decode: word address, pop/push qualification, space check.
  always_comb begin
    // phys[19:1] computed directly: cs*8 + ip/2 modulo 2^19.
    word_addr_c = {cs, 3'b000} + {4'b0000, fetch_ip[15:1]};
    pop_c       = fifo_rd_en && (count != '0);
    ack_push_c  = (state == FETCH) && mem_ack && !load_new_ip;
    space_ok_c  = fetch_ip[0] ? (count <= CNT_W'(FIFO_DEPTH - 1))
                              : (count <= CNT_W'(FIFO_DEPTH - 2));
    push_cnt_c  = '0;
    if (ack_push_c) push_cnt_c = fetch_ip[0] ? CNT_W'(1) : CNT_W'(2);
    wr_ptr_1_c  = ptr_inc(wr_ptr);
    wr_ptr_2_c  = ptr_inc(wr_ptr_1_c);
  end

  assign fifo_empty   = (count == '0);
  assign fifo_rd_data = ring[rd_ptr];

  // Byte storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (reset_n && ack_push_c) begin
      if (fetch_ip[0]) begin
        ring[wr_ptr] <= mem_data[15:8];
      end else begin
        ring[wr_ptr]     <= mem_data[7:0];
        ring[wr_ptr_1_c] <= mem_data[15:8];
      end
    end
  end

  // Fetch FSM, queue bookkeeping and bus request registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cs          <= RESET_CS;
      fetch_ip    <= RESET_IP;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      mem_access  <= 1'b0;
      mem_address <= '0;
    end else if (load_new_ip) begin
      // Redirect wins: flush queue, retarget, and park any open request.
      cs       <= new_cs;
      fetch_ip <= new_ip;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if (state != IDLE) begin
        if (mem_ack) begin
          state      <= IDLE;
          mem_access <= 1'b0;
        end else begin
          state <= DISCARD;
        end
      end
    end else begin
      if (pop_c) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + push_cnt_c - CNT_W'(pop_c);
      case (state)
        IDLE: begin
          if (space_ok_c) begin
            state       <= FETCH;
            mem_access  <= 1'b1;
            mem_address <= word_addr_c;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            state      <= IDLE;
            mem_access <= 1'b0;
            if (fetch_ip[0]) begin
              fetch_ip <= fetch_ip + 16'd1;
              wr_ptr   <= wr_ptr_1_c;
            end else begin
              fetch_ip <= fetch_ip + 16'd2;
              wr_ptr   <= wr_ptr_2_c;
            end
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            state      <= IDLE;
            mem_access <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          mem_access <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch.sv
// Self-checking bench for prefetch: a queue-based behavioural model tracks the
// byte stream and the outstanding bus request; every cycle the DUT outputs are
// compared against it, plus literal expectations for the directed scenarios.
module tb_prefetch;

  localparam int unsigned DEPTH = 6;

  logic        clk;
  logic        reset_n;
  logic        load_new_ip;
  logic [15:0] new_cs;
  logic [15:0] new_ip;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic        mem_access;
  logic        mem_ack;
  logic [18:0] mem_address;
  logic [15:0] mem_data;

  prefetch #(
    .FIFO_DEPTH(DEPTH),
    .RESET_CS  (16'hFFFF),
    .RESET_IP  (16'h0000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_new_ip (load_new_ip),
    .new_cs      (new_cs),
    .new_ip      (new_ip),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .mem_access  (mem_access),
    .mem_ack     (mem_ack),
    .mem_address (mem_address),
    .mem_data    (mem_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [7:0]    mq[$];
  logic [15:0] m_cs;
  logic [15:0] m_ip;
  bit          m_pend;
  bit          m_disc;
  logic [18:0] m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the specification's rules, applied to the model.
  task automatic model_step(input bit rst, input bit ld, input logic [15:0] ncs,
                            input logic [15:0] nip, input bit rd, input bit ack,
                            input logic [15:0] data);
    int   free;
    bit   pop;
    logic [19:0] phys;
    if (rst) begin
      mq.delete();
      m_cs = 16'hFFFF; m_ip = 16'h0000; m_pend = 0; m_disc = 0;
    end else if (ld) begin
      mq.delete();
      m_cs = ncs; m_ip = nip;
      if (m_pend && ack) begin m_pend = 0; m_disc = 0; end
      else if (m_pend) m_disc = 1;
    end else begin
      free = int'(DEPTH) - mq.size();
      pop  = rd && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (m_pend) begin
        if (ack) begin
          if (!m_disc) begin
            if (m_ip[0]) begin
              mq.push_back(data[15:8]);
              m_ip = m_ip + 16'd1;
            end else begin
              mq.push_back(data[7:0]);
              mq.push_back(data[15:8]);
              m_ip = m_ip + 16'd2;
            end
          end
          m_pend = 0; m_disc = 0;
        end
      end else if (m_ip[0] ? (free >= 1) : (free >= 2)) begin
        phys   = {m_cs, 4'h0} + {4'h0, m_ip};
        m_addr = phys[19:1];
        m_pend = 1; m_disc = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("mem_access", 32'(mem_access), 32'(m_pend));
    if (m_pend) chk("mem_address", 32'(mem_address), 32'(m_addr));
    chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
    if (mq.size() > 0) chk("fifo_rd_data", 32'(fifo_rd_data), 32'(mq[0]));
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic tick(input bit rst, input bit ld, input logic [15:0] ncs,
                      input logic [15:0] nip, input bit rd, input bit ack,
                      input logic [15:0] data);
    reset_n     = !rst;
    load_new_ip = ld;
    new_cs      = ncs;
    new_ip      = nip;
    fifo_rd_en  = rd;
    mem_ack     = ack;
    mem_data    = data;
    model_step(rst, ld, ncs, nip, rd, ack, data);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    tick(0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
  endtask

  initial begin
    bit [7:0] exp_bytes [4];
    int n;
    exp_bytes[0] = 8'h66; exp_bytes[1] = 8'h55; exp_bytes[2] = 8'h88; exp_bytes[3] = 8'h77;

    // Reset and default first fetch
    tick(1, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    tick(1, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    chk("rst_access", 32'(mem_access), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    idle();
    chk("first_access", 32'(mem_access), 32'd1);
    chk("first_addr", 32'(mem_address), 32'h7FFF8);
    tick(0, 0, 16'h0, 16'h0, 0, 1, 16'h1234);
    chk("ack_access_low", 32'(mem_access), 32'd0);
    chk("byte0", 32'(fifo_rd_data), 32'h34);
    tick(0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
    chk("byte1", 32'(fifo_rd_data), 32'h12);
    chk("second_addr", 32'(mem_address), 32'h7FFF9);
    tick(0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
    chk("drained_empty", 32'(fifo_empty), 32'd1);

    // Redirect with request outstanding, then odd-IP fetch
    tick(0, 1, 16'h0000, 16'h0101, 0, 0, 16'h0);
    chk("disc_access_held", 32'(mem_access), 32'd1);
    chk("disc_addr_held", 32'(mem_address), 32'h7FFF9);
    tick(0, 0, 16'h0, 16'h0, 0, 1, 16'hBEEF);
    chk("disc_dropped_empty", 32'(fifo_empty), 32'd1);
    chk("disc_access_low", 32'(mem_access), 32'd0);
    idle();
    chk("odd_addr", 32'(mem_address), 32'h00080);
    tick(0, 0, 16'h0, 16'h0, 0, 1, 16'hABCD);
    chk("odd_byte", 32'(fifo_rd_data), 32'hAB);
    idle();
    chk("odd_next_addr", 32'(mem_address), 32'h00081);

    // Pop and ack in the same cycle with three bytes queued
    tick(0, 0, 16'h0, 16'h0, 0, 1, 16'h5566);
    idle();
    tick(0, 0, 16'h0, 16'h0, 1, 1, 16'h7788);
    for (int i = 0; i < 4; i++) begin
      chk("popack_order", 32'(fifo_rd_data), 32'(exp_bytes[i]));
      tick(0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
    end
    chk("popack_count4_empty", 32'(fifo_empty), 32'd1);

    // Fill to depth with no pops
    tick(0, 1, 16'h0000, 16'h0200, 0, 0, 16'h0);
    tick(0, 0, 16'h0, 16'h0, 0, 1, 16'h0);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!m_pend && n < 8) begin idle(); n++; end
      chk("fill_issue", 32'(mem_access), 32'd1);
      tick(0, 0, 16'h0, 16'h0, 0, 1, 16'($urandom));
    end
    idle(); idle(); idle();
    chk("full_no_req", 32'(mem_access), 32'd0);
    tick(0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
    chk("free1_no_req_a", 32'(mem_access), 32'd0);
    idle();
    chk("free1_no_req_b", 32'(mem_access), 32'd0);
    tick(0, 0, 16'h0, 16'h0, 1, 0, 16'h0);
    chk("free2_pop_cycle", 32'(mem_access), 32'd0);
    idle();
    chk("free2_req", 32'(mem_access), 32'd1);
    chk("free2_addr", 32'(mem_address), 32'h00103);

    // Offset wrap within the segment
    tick(0, 1, 16'h1000, 16'hFFFE, 0, 0, 16'h0);
    tick(0, 0, 16'h0, 16'h0, 0, 1, 16'h0);
    idle();
    chk("wrap_addr_hi", 32'(mem_address), 32'h0FFFF);
    tick(0, 0, 16'h0, 16'h0, 0, 1, 16'h4321);
    idle();
    chk("wrap_addr_lo", 32'(mem_address), 32'h08000);

    // Reset with an access outstanding drops it
    tick(1, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    chk("rst_drop_access", 32'(mem_access), 32'd0);
    chk("rst_drop_empty", 32'(fifo_empty), 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bit r_rst, r_ld, r_rd, r_ack;
      r_rst = ($urandom_range(0, 299) == 0);
      r_ld  = ($urandom_range(0, 31) == 0);
      r_rd  = ($urandom_range(0, 1) == 1);
      r_ack = m_pend && ($urandom_range(0, 2) != 0);
      tick(r_rst, r_ld, 16'($urandom), 16'($urandom), r_rd, r_ack, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
